// File: rtl/truth_table_checker.sv
// Response checker for an N-input combinational gate: compares sampled gate output
// against an expected truth table, tracks input coverage and mismatches, and reports pass/fail.
module truth_table_checker #(
    parameter int unsigned                  N_IN     = 4,
    parameter logic [(1 << N_IN)-1:0]      EXPECTED = 16'h8000,
    parameter int unsigned                  TIMEOUT  = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sample_valid,
    input  logic [N_IN-1:0]         in_vec,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timed_out,
    output logic [7:0]              err_count,
    output logic [N_IN-1:0]         first_err_idx,
    output logic [(1 << N_IN)-1:0]  seen_mask
);

    localparam int unsigned NCOMB = 1 << N_IN;
    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cycle_cnt;
    logic [CW-1:0]    cycle_next;
    logic [NCOMB-1:0] seen_upd;
    logic             mismatch;
    logic             cover_hit;
    logic             tmo_hit;

    always_comb begin
        seen_upd   = seen_mask;
        if (sample_valid)
            seen_upd = seen_mask | (NCOMB'(1) << in_vec);
        mismatch   = sample_valid && (dut_out != EXPECTED[in_vec]);
        cycle_next = cycle_cnt + 1'b1;
        cover_hit  = &seen_upd;
        tmo_hit    = (TIMEOUT != 0) && (cycle_next == CW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Coverage is evaluated with the current sample folded in, so it outranks a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cover_hit || tmo_hit) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = done && (&seen_mask) && (err_count == '0) && !timed_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt     <= '0;
            timed_out     <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            seen_mask     <= '0;
        end else begin
            case (state)
                RUN: begin
                    cycle_cnt <= cycle_next;
                    seen_mask <= seen_upd;
                    timed_out <= tmo_hit && !cover_hit;
                    if (mismatch) begin
                        // err_count never returns to zero within a run, so zero marks "no error yet"
                        if (err_count == '0)
                            first_err_idx <= in_vec;
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        cycle_cnt     <= '0;
                        timed_out     <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        seen_mask     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: a TIMEOUT=20 instance for general runs
// and a TIMEOUT=0 instance for the long saturation run, both fed the same stimulus.
module tb_truth_table_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        dut_out = 1'b0;

    logic        d_busy, d_done, d_pass, d_tmo;
    logic [7:0]  d_err;
    logic [3:0]  d_first;
    logic [15:0] d_seen;
    logic        s_busy, s_done, s_pass, s_tmo;
    logic [7:0]  s_err;
    logic [3:0]  s_first;
    logic [15:0] s_seen;

    always #5 clk = ~clk;

    truth_table_checker #(.N_IN(4), .EXPECTED(16'h8000), .TIMEOUT(20)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .in_vec(in_vec), .dut_out(dut_out), .busy(d_busy), .done(d_done),
        .pass(d_pass), .timed_out(d_tmo), .err_count(d_err),
        .first_err_idx(d_first), .seen_mask(d_seen)
    );

    truth_table_checker #(.N_IN(4), .EXPECTED(16'h8000), .TIMEOUT(0)) u_sat (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .in_vec(in_vec), .dut_out(dut_out), .busy(s_busy), .done(s_done),
        .pass(s_pass), .timed_out(s_tmo), .err_count(s_err),
        .first_err_idx(s_first), .seen_mask(s_seen)
    );

    // sel picks which instance the checks observe
    logic        sel = 1'b0;
    logic        o_busy, o_done, o_pass, o_tmo;
    logic [7:0]  o_err;
    logic [3:0]  o_first;
    logic [15:0] o_seen;
    assign o_busy  = sel ? s_busy  : d_busy;
    assign o_done  = sel ? s_done  : d_done;
    assign o_pass  = sel ? s_pass  : d_pass;
    assign o_tmo   = sel ? s_tmo   : d_tmo;
    assign o_err   = sel ? s_err   : d_err;
    assign o_first = sel ? s_first : d_first;
    assign o_seen  = sel ? s_seen  : d_seen;

    typedef struct {
        logic [7:0]  err;
        logic [15:0] seen;
        logic [3:0]  first;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  m_err;
    logic [15:0] m_seen;
    logic [3:0]  m_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic and_ref(input logic [3:0] k);
        return &k;
    endfunction

    task automatic model_clear();
        m_err = '0;
        m_seen = '0;
        m_first = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
        check("start_busy", o_busy, 1);
    endtask

    // Drive one sample, push the expected post-sample state, then pop and compare.
    task automatic send(input logic [3:0] k, input logic out);
        exp_t e;
        exp_t got;
        @(negedge clk);
        sample_valid = 1'b1;
        in_vec = k;
        dut_out = out;
        m_seen[k] = 1'b1;
        if (out != and_ref(k)) begin
            if (m_err == 0) m_first = k;
            if (m_err != 8'd255) m_err = m_err + 8'd1;
        end
        e.err = m_err;
        e.seen = m_seen;
        e.first = m_first;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        got = sb.pop_front();
        check("smp_err", o_err, got.err);
        check("smp_seen", o_seen, got.seen);
        check("smp_first", o_first, got.first);
    endtask

    task automatic check_final(input string tag, input logic exp_tmo);
        check({tag, "_done"}, o_done, 1);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_tmo"}, o_tmo, exp_tmo);
        check({tag, "_err"}, o_err, m_err);
        check({tag, "_first"}, o_first, m_first);
        check({tag, "_seen"}, o_seen, m_seen);
        check({tag, "_pass"}, o_pass, ((&m_seen) && m_err == 0 && !exp_tmo) ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_pass"}, o_pass, 0);
        check({tag, "_tmo"}, o_tmo, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_first"}, o_first, 0);
        check({tag, "_seen"}, o_seen, 0);
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sel = 1'b0;
        check_zero("rst");

        // correct AND, exhaustive sweep
        do_start();
        for (int i = 0; i < 16; i++) send(4'(i), and_ref(4'(i)));
        check_final("and_ok", 1'b0);
        check("and_ok_passval", o_pass, 1);
        // samples in DONE are ignored
        @(negedge clk);
        sample_valid = 1'b1;
        in_vec = 4'd0;
        dut_out = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("done_ignore_err", o_err, 0);
        check("done_ignore_done", o_done, 1);

        // stuck-at-0 output; start from DONE clears results
        do_start();
        check("restart_seen", o_seen, 0);
        for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
        check_final("sa0", 1'b0);

        // partial coverage then timeout
        do_reset();
        do_start();
        for (int i = 0; i < 8; i++) send(4'(i), and_ref(4'(i)));
        cnt = 0;
        while (!o_done && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("tmo_cycles", cnt, 12);
        check_final("tmo", 1'b1);

        // duplicates with stuck-at-1
        do_reset();
        do_start();
        send(4'd3, 1'b1);
        send(4'd3, 1'b1);
        send(4'd5, 1'b1);
        for (int i = 0; i < 16; i++) send(4'(i), 1'b1);
        check_final("dup", 1'b0);
        check("dup_err18", o_err, 18);

        // saturation on the no-timeout instance
        sel = 1'b1;
        do_reset();
        do_start();
        for (int i = 0; i < 300; i++) send(4'd0, 1'b1);
        for (int i = 0; i < 16; i++) send(4'(i), 1'b1);
        check_final("sat", 1'b0);
        check("sat_err255", o_err, 255);

        // reset mid-run, then a clean sweep
        sel = 1'b0;
        do_reset();
        do_start();
        for (int i = 0; i < 6; i++) send(4'(i), 1'b0);
        do_reset();
        check_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_nodone", o_done, 0);
        do_start();
        for (int i = 0; i < 16; i++) send(4'(15 - i), and_ref(4'(15 - i)));
        check_final("after_rst", 1'b0);
        check("after_rst_passval", o_pass, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
